// File: rtl/adc_spi_cfg_sequencer.sv
// 3-wire SPI write sequencer for the ADC configuration port: one 16-bit
// {write=0, addr, data} frame per accepted request, SPI mode 0, registered outputs.
module adc_spi_cfg_sequencer #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [6:0] cfg_addr,
    input  logic [7:0] cfg_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] wr_count,
    output logic       adc_csbn,
    output logic       adc_sclk,
    output logic       adc_sdio
);
    localparam int MAXD = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW   = $clog2(MAXD + 1);
    localparam logic [CW-1:0] DIV_LD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic          hi_q, hi_d;
    logic [15:0]   shreg_q, shreg_d;
    logic          csbn_q, csbn_d, sclk_q, sclk_d, sdio_q, sdio_d;
    logic          ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic [7:0]    wr_count_q, wr_count_d;
    logic          frame_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        hi_d    = hi_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: if (cfg_valid && ready_q) begin
                state_d = SETUP;
                cnt_d   = DIV_LD;
                shreg_d = {1'b0, cfg_addr, cfg_data};
            end
            SETUP: if (cnt_q == '0) begin
                state_d = SHIFT;
                cnt_d   = DIV_LD;
                bit_d   = 4'd15;
                hi_d    = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            SHIFT: if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (hi_q) begin
                // sclk falls: present the next bit so it is settled before the next rise
                hi_d    = 1'b0;
                cnt_d   = DIV_LD;
                shreg_d = {shreg_q[14:0], 1'b0};
            end else if (bit_q == 4'd0) begin
                state_d = HOLD;
                cnt_d   = DIV_LD;
            end else begin
                bit_d = bit_q - 4'd1;
                hi_d  = 1'b1;
                cnt_d = DIV_LD;
            end
            HOLD: if (cnt_q == '0) begin
                state_d = GAP;
                cnt_d   = GAP_LD;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            GAP: if (cnt_q == '0) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the pins line up with the state cycles
        frame_d    = state_d inside {SETUP, SHIFT, HOLD};
        csbn_d     = !frame_d;
        sclk_d     = (state_d == SHIFT) && hi_d;
        sdio_d     = frame_d && shreg_d[15];
        ready_d    = (state_d == IDLE);
        busy_d     = !ready_d;
        done_d     = (state_d == GAP) && (cnt_d == '0);
        wr_count_d = wr_count_q + 8'(done_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= 4'd0;
            hi_q       <= 1'b0;
            shreg_q    <= 16'd0;
            csbn_q     <= 1'b1;
            sclk_q     <= 1'b0;
            sdio_q     <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_count_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            hi_q       <= hi_d;
            shreg_q    <= shreg_d;
            csbn_q     <= csbn_d;
            sclk_q     <= sclk_d;
            sdio_q     <= sdio_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign cfg_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wr_count  = wr_count_q;
    assign adc_csbn  = csbn_q;
    assign adc_sclk  = sclk_q;
    assign adc_sdio  = sdio_q;
endmodule

// File: tb/tb_adc_spi_cfg_sequencer.sv
// Scoreboard bench: each accepted write pushes its frame word and accept edge;
// the pin monitors rebuild frames from sclk rises and check them at done.
module tb_adc_spi_cfg_sequencer;
    localparam int CD = 2, GP = 4;
    localparam int FRAME = 34 * CD;

    logic clk = 1'b0, rst = 1'b1;
    logic cfg_valid = 1'b0, cfg_valid1 = 1'b0;
    logic [6:0] cfg_addr = '0, cfg_addr1 = '0;
    logic [7:0] cfg_data = '0, cfg_data1 = '0;
    logic cfg_ready, busy, done, adc_csbn, adc_sclk, adc_sdio;
    logic cfg_ready1, busy1, done1, adc_csbn1, adc_sclk1, adc_sdio1;
    logic [7:0] wr_count, wr_count1;

    adc_spi_cfg_sequencer #(.CLK_DIV(CD), .GAP_CYCLES(GP)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy), .done(done),
        .wr_count(wr_count), .adc_csbn(adc_csbn), .adc_sclk(adc_sclk), .adc_sdio(adc_sdio));

    adc_spi_cfg_sequencer #(.CLK_DIV(1), .GAP_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid1), .cfg_ready(cfg_ready1),
        .cfg_addr(cfg_addr1), .cfg_data(cfg_data1), .busy(busy1), .done(done1),
        .wr_count(wr_count1), .adc_csbn(adc_csbn1), .adc_sclk(adc_sclk1), .adc_sdio(adc_sdio1));

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_cmp = 0, n_err = 0;

    typedef struct {
        logic [15:0] word;
        int          t0;
    } exp_t;
    exp_t sb[$], sb1[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor for the CLK_DIV=2 instance: cycle-exact frame checks
    logic prev_csbn = 1'b1, prev_sclk = 1'b0, have_prev = 1'b0;
    logic [15:0] bits = '0;
    logic [7:0] exp_cnt = '0;
    int low_start = 0, low_end = 0, high_start = 0, rises = 0, total_rises = 0, ready_n = -1;

    always @(negedge clk) begin : mon0
        exp_t e;
        int n;
        n = edge_cnt;
        if (rst) begin
            sb.delete();
            exp_cnt = '0; prev_csbn = 1'b1; prev_sclk = 1'b0; have_prev = 1'b0;
            rises = 0; ready_n = -1;
        end else begin
            if (n == ready_n) chk("ready_after_done", 32'(cfg_ready), 1);
            if (!adc_csbn && prev_csbn) begin
                if (have_prev) chk("csbn_high_gap_ok", 32'((n - high_start) >= GP + 1), 1);
                low_start = n; rises = 0; bits = '0;
            end
            if (adc_csbn && !prev_csbn) begin
                low_end = n - 1; high_start = n; have_prev = 1'b1;
            end
            if (adc_sclk && !prev_sclk) begin
                chk("csbn_at_sclk_rise", 32'(adc_csbn), 0);
                if (!adc_csbn) begin
                    bits = {bits[14:0], adc_sdio};
                    rises++; total_rises++;
                end
            end
            if (done) begin
                chk("sb_nonempty_at_done", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    exp_cnt = exp_cnt + 8'd1;
                    chk("frame_word", 32'(bits), 32'(e.word));
                    chk("sclk_rises", 32'(rises), 16);
                    chk("csbn_fall_cycle", 32'(low_start), 32'(e.t0 + 1));
                    chk("csbn_last_low", 32'(low_end), 32'(e.t0 + FRAME));
                    chk("done_cycle", 32'(n), 32'(e.t0 + FRAME + GP));
                    chk("wr_count", 32'(wr_count), 32'(exp_cnt));
                    ready_n = n + 1;
                end
            end
            prev_csbn = adc_csbn; prev_sclk = adc_sclk;
        end
    end

    // Monitor for the CLK_DIV=1 instance: frame contents and counter only
    logic prev_csbn1 = 1'b1, prev_sclk1 = 1'b0;
    logic [15:0] bits1 = '0;
    logic [7:0] exp_cnt1 = '0;
    int rises1 = 0, frames1 = 0;

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst) begin
            sb1.delete();
            exp_cnt1 = '0; prev_csbn1 = 1'b1; prev_sclk1 = 1'b0; frames1 = 0;
        end else begin
            if (!adc_csbn1 && prev_csbn1) begin
                bits1 = '0; rises1 = 0;
            end
            if (adc_sclk1 && !prev_sclk1 && !adc_csbn1) begin
                bits1 = {bits1[14:0], adc_sdio1};
                rises1++;
            end
            if (done1) begin
                chk("sb1_nonempty_at_done", 32'(sb1.size() != 0), 1);
                if (sb1.size() != 0) begin
                    e = sb1.pop_front();
                    exp_cnt1 = exp_cnt1 + 8'd1;
                    frames1++;
                    chk("fast_frame_word", 32'(bits1), 32'(e.word));
                    chk("fast_sclk_rises", 32'(rises1), 16);
                    chk("fast_wr_count", 32'(wr_count1), 32'(exp_cnt1));
                end
            end
            prev_csbn1 = adc_csbn1; prev_sclk1 = adc_sclk1;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic wr(input bit sel, input logic [6:0] a, input logic [7:0] d,
                      input bit keep, output int t0);
        bit ok;
        ok = 1'b0;
        t0 = -1;
        if (sel) begin cfg_valid1 = 1'b1; cfg_addr1 = a; cfg_data1 = d; end
        else     begin cfg_valid  = 1'b1; cfg_addr  = a; cfg_data  = d; end
        for (int i = 0; i < 400 && !ok; i++) begin
            if ((sel ? cfg_ready1 : cfg_ready) == 1'b1) begin
                ok = 1'b1;
                t0 = edge_cnt;
                if (sel) sb1.push_back('{{1'b0, a, d}, t0});
                else     sb.push_back('{{1'b0, a, d}, t0});
            end
            @(negedge clk);
        end
        if (!keep) begin
            if (sel) cfg_valid1 = 1'b0; else cfg_valid = 1'b0;
        end
        chk(sel ? "accept_fast" : "accept", 32'(ok), 1);
    endtask

    task automatic drain(input bit sel);
        for (int i = 0; i < 3000 && (sel ? sb1.size() : sb.size()) != 0; i++) @(negedge clk);
        chk(sel ? "drain_fast" : "drain", 32'(sel ? sb1.size() : sb.size()), 0);
    endtask

    initial begin
        int ta, tb, r0;
        // Reset held: outputs parked regardless of cfg_valid
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cfg_valid = ~cfg_valid;
            chk("rst_csbn", 32'(adc_csbn), 1);
            chk("rst_sclk", 32'(adc_sclk), 0);
            chk("rst_sdio", 32'(adc_sdio), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_wr_count", 32'(wr_count), 0);
            chk("rst_ready", 32'(cfg_ready), 0);
        end
        cfg_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("ready_before_edge", 32'(cfg_ready), 0);
        @(negedge clk);
        chk("ready_first_edge", 32'(cfg_ready), 1);

        // Single write
        wr(0, 7'h08, 8'hA5, 0, ta);
        chk("busy_after_accept", 32'(busy), 1);
        chk("ready_after_accept", 32'(cfg_ready), 0);
        drain(0);
        chk("t2_wr_count", 32'(wr_count), 1);

        // Back-to-back with cfg_valid held high
        r0 = total_rises;
        wr(0, 7'h01, 8'h3C, 1, ta);
        wr(0, 7'h14, 8'h00, 0, tb);
        chk("b2b_accept_gap", 32'(tb - ta), 32'(FRAME + GP + 1));
        drain(0);
        chk("b2b_total_rises", 32'(total_rises - r0), 32);
        chk("t3_wr_count", 32'(wr_count), 3);

        // Request while busy is dropped; frame keeps the captured word
        wr(0, 7'h2A, 8'h5C, 0, ta);
        while (edge_cnt < ta + 10) @(negedge clk);
        cfg_valid = 1'b1; cfg_addr = 7'h7F; cfg_data = 8'hFF;
        @(negedge clk);
        cfg_valid = 1'b0;
        drain(0);
        repeat (100) @(negedge clk);
        chk("t4_wr_count", 32'(wr_count), 4);

        // Reset between the 5th and 6th sclk rise
        wr(0, 7'h33, 8'hC3, 0, ta);
        for (int i = 0; i < 200 && rises != 5; i++) @(negedge clk);
        chk("t5_reached_rise5", 32'(rises), 5);
        #1 rst = 1'b1;
        #1;
        chk("t5_csbn_async", 32'(adc_csbn), 1);
        chk("t5_sclk_async", 32'(adc_sclk), 0);
        chk("t5_done_async", 32'(done), 0);
        chk("t5_busy_async", 32'(busy), 0);
        chk("t5_wr_count_async", 32'(wr_count), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_wr_count_after", 32'(wr_count), 0);
        chk("t5_ready_after", 32'(cfg_ready), 1);
        wr(0, 7'h55, 8'h0F, 0, ta);
        drain(0);
        chk("t5_wr_count_new", 32'(wr_count), 1);

        // 256 writes on the fast instance: counter wraps to zero
        for (int i = 0; i < 256; i++)
            wr(1, 7'($urandom), 8'($urandom), i != 255, tb);
        drain(1);
        chk("t6_frames", 32'(frames1), 256);
        chk("t6_wr_count_wrap", 32'(wr_count1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
